// File: rtl/pipe_mac.sv
// rtl/pipe_mac.sv - 3-stage pipelined multiply-add/subtract with valid/ready stall; PIPE_MAC_SAT_EN selects saturation
module pipe_mac #(
    parameter int AW     = 4,
    parameter int BW     = 4,
    parameter int CW     = 4,
    parameter int YW     = 9,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic [CW-1:0] c,
    input  logic          sub,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [YW-1:0] y,
    output logic          ovf
);

    // Internal arithmetic width holds the exact product +/- addend with sign headroom.
    localparam int PW = AW + BW;
    localparam int IW = ((PW > CW) ? PW : CW) + 2;
    // Comparison width covers both the internal result and the output range limits.
    localparam int WW = ((IW > YW) ? IW : YW) + 2;

    localparam logic [WW-1:0] ONE = {{(WW-1){1'b0}}, 1'b1};
    localparam logic signed [WW-1:0] MAXV = (SIGNED != 0) ? $signed((ONE << (YW-1)) - ONE)
                                                          : $signed((ONE << YW) - ONE);
    localparam logic signed [WW-1:0] MINV = (SIGNED != 0) ? $signed(~((ONE << (YW-1)) - ONE))
                                                          : $signed({WW{1'b0}});

    logic          v1, v2, v3;
    logic          rdy1, rdy2, rdy3;

    logic [AW-1:0] a1;
    logic [BW-1:0] b1;
    logic [CW-1:0] c1;
    logic          sub1;

    logic signed [IW-1:0] p2;
    logic signed [IW-1:0] c2;
    logic                 sub2;

    logic signed [IW-1:0] ea, eb, ec, prod, r;
    logic signed [WW-1:0] rw;
    logic                 hi, lo;
    logic [YW-1:0]        y_next;

    // Each stage may advance when downstream can take its item or it holds nothing.
    assign rdy3      = out_ready | ~v3;
    assign rdy2      = rdy3 | ~v2;
    assign rdy1      = rdy2 | ~v1;
    assign in_ready  = rdy1;
    assign out_valid = v3;

    // Operand extension and the two arithmetic steps between the stage registers.
    always_comb begin
        ea     = {{(IW-AW){(SIGNED != 0) & a1[AW-1]}}, a1};
        eb     = {{(IW-BW){(SIGNED != 0) & b1[BW-1]}}, b1};
        ec     = {{(IW-CW){(SIGNED != 0) & c1[CW-1]}}, c1};
        prod   = ea * eb;
        r      = sub2 ? (p2 - c2) : (p2 + c2);
        rw     = {{(WW-IW){r[IW-1]}}, r};
        hi     = (rw > MAXV);
        lo     = (rw < MINV);
`ifdef PIPE_MAC_SAT_EN
        if (hi) begin
            y_next = MAXV[YW-1:0];
        end else if (lo) begin
            y_next = MINV[YW-1:0];
        end else begin
            y_next = rw[YW-1:0];
        end
`else
        y_next = rw[YW-1:0];
`endif
    end

    // Stage 1: capture the raw operands and operation select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            c1   <= '0;
            sub1 <= 1'b0;
        end else if (rdy1) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1   <= a;
                b1   <= b;
                c1   <= c;
                sub1 <= sub;
            end
        end
    end

    // Stage 2: register the extended product alongside the extended addend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            p2   <= '0;
            c2   <= '0;
            sub2 <= 1'b0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                p2   <= prod;
                c2   <= ec;
                sub2 <= sub1;
            end
        end
    end

    // Stage 3: register the final result and its range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3  <= 1'b0;
            y   <= '0;
            ovf <= 1'b0;
        end else if (rdy3) begin
            v3 <= v2;
            if (v2) begin
                y   <= y_next;
                ovf <= hi | lo;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mac.sv
// tb/tb_pipe_mac.sv - scoreboard bench for pipe_mac (default unsigned and signed YW=6 instances)
module tb_pipe_mac;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, sub, out_valid, out_ready, ovf;
    logic [3:0] a, b, c;
    logic [8:0] y;

    logic       s_in_valid, s_in_ready, ssub, s_out_valid, s_out_ready, sovf;
    logic [3:0] sa, sb, sc;
    logic [5:0] sy;

    logic [9:0] exp_main;
    logic [6:0] exp_s;
    logic [9:0] q[$];
    logic [6:0] sq[$];

    int ntotal = 0;
    int npass  = 0;
    int deliv  = 0;
    int base;

    always #5 clk = ~clk;

    pipe_mac u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf)
    );

    pipe_mac #(.YW(6), .SIGNED(1)) u_sdut (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(sa), .b(sb), .c(sc), .sub(ssub), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .y(sy), .ovf(sovf)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference for the default unsigned YW=9 instance.
    function automatic logic [9:0] model(input int ma, input int mb, input int mc, input bit ms);
        int r;
        logic o;
        logic [8:0] yy;
        r  = ms ? (ma * mb - mc) : (ma * mb + mc);
        o  = (r < 0) || (r > 511);
`ifdef PIPE_MAC_SAT_EN
        yy = (r < 0) ? 9'd0 : (r > 511) ? 9'd511 : r[8:0];
`else
        yy = r[8:0];
`endif
        return {o, yy};
    endfunction

    // Scoreboard push on every accepted input.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) q.push_back(exp_main);
        if (rst_n && s_in_valid && s_in_ready) sq.push_back(exp_s);
    end

    // Monitor: compare every delivered result against the oldest expectation.
    always @(negedge clk) begin
        logic [9:0] e;
        logic [6:0] se;
        if (rst_n && out_valid && out_ready) begin
            deliv++;
            if (q.size() == 0) chk("unexpected_output", 1, 0);
            else begin
                e = q.pop_front();
                chk("y", y, e[8:0]);
                chk("ovf", ovf, e[9]);
            end
        end
        if (rst_n && s_out_valid && s_out_ready) begin
            if (sq.size() == 0) chk("s_unexpected_output", 1, 0);
            else begin
                se = sq.pop_front();
                chk("s_y", sy, se[5:0]);
                chk("s_ovf", sovf, se[6]);
            end
        end
    end

    task automatic drive(input logic [3:0] ta, input logic [3:0] tb_, input logic [3:0] tc,
                         input logic ts, input logic [9:0] e);
        bit acc;
        a = ta; b = tb_; c = tc; sub = ts; exp_main = e; in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("drive_timeout", 0, 1);
    endtask

    task automatic sdrive(input logic [3:0] ta, input logic [3:0] tb_, input logic [3:0] tc,
                          input logic ts, input logic [6:0] e);
        bit acc;
        sa = ta; sb = tb_; sc = tc; ssub = ts; exp_s = e; s_in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = s_in_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("sdrive_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; s_in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int i;
        bit acc;
        rst_n = 1'b0;
        in_valid = 0; a = 0; b = 0; c = 0; sub = 0; out_ready = 1;
        s_in_valid = 0; sa = 0; sb = 0; sc = 0; ssub = 0; s_out_ready = 1;
        exp_main = '0; exp_s = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Latency and basic arithmetic
        drive(4'd3, 4'd5, 4'd2, 1'b0, {1'b0, 9'd17});
        in_valid = 1'b0;
        chk("lat_e1", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_e2", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_e3", out_valid, 1);
        drive(4'd15, 4'd15, 4'd15, 1'b0, {1'b0, 9'd240});
        drive(4'd15, 4'd15, 4'd15, 1'b1, {1'b0, 9'd210});
        idle(4);

        // Unsigned underflow
`ifdef PIPE_MAC_SAT_EN
        drive(4'd2, 4'd3, 4'd9, 1'b1, {1'b1, 9'd0});
        drive(4'd0, 4'd0, 4'd1, 1'b1, {1'b1, 9'd0});
`else
        drive(4'd2, 4'd3, 4'd9, 1'b1, {1'b1, 9'd509});
        drive(4'd0, 4'd0, 4'd1, 1'b1, {1'b1, 9'd511});
`endif
        drive(4'd0, 4'd0, 4'd0, 1'b1, {1'b0, 9'd0});
        idle(4);

        // Signed YW=6
`ifdef PIPE_MAC_SAT_EN
        sdrive(4'b1000, 4'b1000, 4'd7, 1'b0, {1'b1, 6'd31});
        sdrive(4'b1000, 4'd7, 4'd7, 1'b1, {1'b1, 6'b100000});
`else
        sdrive(4'b1000, 4'b1000, 4'd7, 1'b0, {1'b1, 6'd7});
        sdrive(4'b1000, 4'd7, 4'd7, 1'b1, {1'b1, 6'd1});
`endif
        sdrive(4'b1100, 4'd2, 4'd3, 1'b1, {1'b0, 6'b110101});
        sdrive(4'd7, 4'd4, 4'd3, 1'b0, {1'b0, 6'd31});
        sdrive(4'b1000, 4'd4, 4'd0, 1'b0, {1'b0, 6'b100000});
        idle(5);

        // Back-pressure: fill, stall, release
        out_ready = 1'b0;
        i = 0;
        for (int n = 0; n < 6; n++) begin
            a = 4'(i + 1); b = 4'(i + 2); c = 4'(i); sub = 1'b0;
            exp_main = model(i + 1, i + 2, i, 1'b0);
            in_valid = 1'b1;
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) i++;
        end
        chk("stall_accepted", i, 3);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        base = deliv;
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (i < 5) begin
                a = 4'(i + 1); b = 4'(i + 2); c = 4'(i); sub = 1'b0;
                exp_main = model(i + 1, i + 2, i, 1'b0);
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            @(negedge clk); acc = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc) i++;
        end
        chk("release_accepted", i, 5);
        chk("release_deliv", deliv - base, 5);
        idle(3);

        // Streaming at full rate
        base = deliv;
        for (int n = 0; n < 20; n++) begin
            a = 4'(n % 16); b = 4'((3 * n) % 16); c = 4'((5 * n) % 16); sub = n[0];
            exp_main = model(n % 16, (3 * n) % 16, (5 * n) % 16, n[0]);
            in_valid = 1'b1;
            @(negedge clk);
            chk("stream_in_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        idle(4);
        chk("stream_deliv", deliv - base, 20);
        chk("q_empty", q.size(), 0);
        chk("sq_empty", sq.size(), 0);

        // Reset with items in flight
        out_ready = 1'b0;
        drive(4'd1, 4'd1, 4'd1, 1'b0, model(1, 1, 1, 1'b0));
        drive(4'd2, 4'd2, 4'd2, 1'b0, model(2, 2, 2, 1'b0));
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_out_valid", out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_y", y, 0);
        q.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        base = deliv;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_no_stale", deliv - base, 0);
        chk("post_rst_out_valid", out_valid, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
